// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-resource arbiter.
// The master side drives requests and release strobes; the slave side returns the grant.
interface req_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
);
  logic               en;
  logic               mode;
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en,
    output mode,
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  mode,
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/req_arbiter.sv
// Eight-way arbiter with fixed-priority or round-robin selection, holding each grant
// until done, request drop, disable, or a hold timeout; all outputs are registered.
module req_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  req_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int               HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam bit               TO_EN       = (MAX_HOLD != 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               valid_q, valid_n;
  logic               to_q, to_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   last_q, last_n;

  logic [IDX_W-1:0]   fix_w;
  logic [IDX_W-1:0]   rr_w;
  logic [IDX_W-1:0]   rr_cand;
  logic               rr_found;
  logic [IDX_W-1:0]   win;
  logic               any_req;

  logic               owner_drop;
  logic               hold_exp;
  logic               other_rel;
  logic               release_now;

  // Fixed mode lets the highest index win; round-robin starts just past the last winner.
  always_comb begin
    fix_w    = '0;
    rr_w     = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i]) begin
        fix_w = IDX_W'(i);
      end
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_cand = last_q + IDX_W'(i);
      if (!rr_found && bus.req[rr_cand]) begin
        rr_w     = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  assign any_req = |bus.req;
  assign win     = bus.mode ? rr_w : fix_w;

  // A timeout is only reported when the hold limit is the sole reason for release.
  assign owner_drop  = ~bus.req[idx_q];
  assign hold_exp    = TO_EN && (cnt_q == HOLD_LAST);
  assign other_rel   = bus.done | owner_drop | ~bus.en;
  assign release_now = other_rel | hold_exp;

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    to_n    = 1'b0;
    cnt_n   = cnt_q;
    last_n  = last_q;
    case (state)
      IDLE: begin
        gnt_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        if (bus.en && any_req) begin
          state_n = GRANT;
          gnt_n   = ONE_HOT0 << win;
          idx_n   = win;
          valid_n = 1'b1;
          cnt_n   = '0;
          last_n  = win;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
          valid_n = 1'b0;
          cnt_n   = '0;
          to_n    = hold_exp & ~other_rel;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // last_q resets to the top index so the first round-robin search begins at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state   <= state_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      to_q    <= to_n;
      cnt_q   <= cnt_n;
      last_q  <= last_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: a cycle-by-cycle vector table followed by
// hand-written timeout and asynchronous-reset sequences.
module tb_req_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  req_arbiter_if #(.NUM_REQ(8), .IDX_W(3)) bus ();

  req_arbiter #(
    .NUM_REQ (8),
    .IDX_W   (3),
    .MAX_HOLD(15),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic e, input logic m, input logic [7:0] r,
                                 input logic d, input logic [7:0] g, input logic [2:0] i,
                                 input logic v, input logic t);
    vec_t x;
    x.en = e; x.mode = m; x.req = r; x.done = d;
    x.gnt = g; x.idx = i; x.valid = v; x.to = t;
    vecs.push_back(x);
  endfunction

  // Inputs change just after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic applyStimulus(input logic e, input logic m, input logic [7:0] r, input logic d);
    bus.en   = e;
    bus.mode = m;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev, input logic et);
    checks++;
    if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_valid !== ev || bus.timeout !== et) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
               name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    //       en    mode  req    done  gnt    idx   valid timeout
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h26, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h26, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h26, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h26, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h26, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h88, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'h88, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    addVec(1'b1, 1'b0, 8'h88, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'h85, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].to);
    end

    // Fixed-mode hold timeout: 15 grant cycles, pulse, then regrant.
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
    checkOutput("to_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    for (int k = 1; k < 15; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
      checkOutput($sformatf("to_hold%0d", k), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
    checkOutput("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
    checkOutput("to_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b1);
    checkOutput("to_done_rel", 8'h00, 3'd0, 1'b0, 1'b0);

    // Round-robin: the timed-out owner drops to lowest priority.
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    checkOutput("rr_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    for (int k = 1; k < 15; k++) begin
      applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
      checkOutput($sformatf("rr_hold5_%0d", k), 8'h20, 3'd5, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    checkOutput("rr_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    checkOutput("rr_to_lowest", 8'h10, 3'd4, 1'b1, 1'b0);

    // done coinciding with the hold limit suppresses the timeout pulse.
    for (int k = 1; k < 15; k++) begin
      applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
      checkOutput($sformatf("rr_hold4_%0d", k), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b1);
    checkOutput("to_coincide", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    checkOutput("rr_after_coincide", 8'h20, 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b1);
    checkOutput("rr_release5", 8'h00, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then round-robin restarts from index 0.
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b0);
    checkOutput("async_pre", 8'h40, 3'd6, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b0);
    checkOutput("rr_after_reset", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Sequential arbiter that shares one resource among 8 requesters.
- Picks a winner in fixed-priority mode (highest index wins) or round-robin mode.
- Holds the grant until the owner releases it, drops its request, or a hold timeout expires.
- Sits in front of the shared datapath and drives its select index and valid.

Parameters:
- NUM_REQ, 8: number of requesters; fixed at 8 for this block.
- IDX_W, 3: width of the grant index.
- MAX_HOLD, 15: maximum consecutive grant cycles before forced release. 0 disables the timeout.
- CNT_W, 4: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbiter enable. When low, no new grants are issued and any active grant is released.
- mode  in  1  0 = fixed priority (req[7] highest); 1 = round-robin.
- req  in  8  request vector, one bit per requester.
- done  in  1  owner's release strobe; only meaningful while gnt_valid=1.
- gnt  out  8  registered one-hot grant. All zeros when no grant.
- gnt_idx  out  3  registered binary index of the granted requester. 0 when no grant.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - hold_cnt=0; last_idx=7, so the first round-robin search starts at index 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req≠0, compute the winner w from req sampled at this edge, then go to GRANT.
  - On that edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=0, last_idx=w.
  - Otherwise remain in IDLE with outputs zero.
- Winner selection, fixed mode: the highest set index of req.
- Winner selection, round-robin mode: search last_idx+1, last_idx+2, … modulo 8. The first set bit wins.
- mode is sampled only in IDLE; changing it during GRANT has no effect on the current grant.
- GRANT, release conditions (checked each edge; any one releases):
  - a) done=1
  - b) req[gnt_idx]=0
  - c) en=0
  - d) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1
- On release: next state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0.
- timeout=1 for exactly that cycle only when (d) is the sole cause. If done, a dropped request, or en=0 coincides with (d), timeout=0.
- Without release: hold_cnt increments, saturating at MAX_HOLD-1. Grant outputs stay stable.
- Latency:
  - Request sampled at edge t gives grant visible after edge t (1 cycle).
  - Release sampled at edge t gives gnt=0 after t; the earliest next grant appears after edge t+1.
  - There is always at least one dead cycle between consecutive grants, including back-to-back grants to the same requester.
- Requests from non-owners during GRANT are ignored; there is no preemption.
- Re-arbitration in IDLE uses the current req vector; no pending requests are latched.
- If the owner's req bit is set again after release, it competes normally.
- In round-robin mode, a requester that timed out is the lowest priority in the next search.
- en=0 in IDLE holds the block in IDLE. last_idx is preserved across enable toggles; only reset clears it.
- Asserting rst_n mid-grant immediately clears all outputs.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0, then release; req=0, en=1.
  - Required: all outputs 0 indefinitely; gnt_valid stays 0.
- Fixed priority:
  - Stimulus: mode=0, req=8'b0010_0110.
  - Required: one cycle later gnt=8'b0010_0000, gnt_idx=5.
  - Then done=1 for one cycle with req unchanged → one dead cycle → gnt_idx=5 again.
- Round-robin rotation:
  - Stimulus: mode=1 after reset, req=8'b1000_0101 held, done pulsed on the first cycle of each grant.
  - Required: gnt_idx sequence 0, 2, 7, 0, 2, each separated by one zero cycle.
- Timeout:
  - Stimulus: MAX_HOLD=15, mode=0, req=8'h10 held, done=0.
  - Required: gnt_valid high for exactly 15 cycles; timeout=1 in the first cycle gnt returns to 0; regrant to index 4 follows.
- Release by request drop and by enable:
  - Stimulus: owner idx 3 drops req[3] mid-grant.
  - Required: gnt=0 the next cycle, timeout=0.
  - Stimulus: repeat with en=0 instead.
  - Required: grant released; no new grant while en=0.
- Async reset mid-grant:
  - Stimulus: grant held on idx 6; assert rst_n=0 between clock edges.
  - Required: gnt, gnt_idx and gnt_valid go 0 without waiting for a clock edge.
  - After release in round-robin mode with req=8'h41: first grant is idx 0 (last_idx reset to 7).
